fixed_attention_head_concat: RTL

- Multi-head concatenation stage. Sits directly downstream of NUM_HEADS self-attention heads, each producing a HEAD_DIM x SEQ_LEN output tensor as a block stream.
- Merges the head streams into one stream of the concatenated tensor (NUM_HEADS*HEAD_DIM x SEQ_LEN), with the same block parallelism.
- Feeds the output projection linear layer.
- No data buffering beyond one output register; ordering is achieved by back-pressuring heads that are not selected.

---
 rtl/fixed_attention_head_concat.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fixed_attention_head_concat.sv
// Merges NUM_HEADS head block streams into one concatenated block stream with row/tensor framing.
// Define ATTENTION_HEAD_CONCAT_STALL_CNT_EN to add the stall_cnt/starve_cnt observability ports.
module fixed_attention_head_concat #(
    parameter int NUM_HEADS              = 4,
    parameter int DATA_WIDTH             = 16,
    parameter int HEAD_TENSOR_SIZE_DIM_0 = 64,
    parameter int HEAD_TENSOR_SIZE_DIM_1 = 32,
    parameter int PARALLELISM_DIM_0      = 4,
    parameter int PARALLELISM_DIM_1      = 4,
    localparam int DEPTH_0 = HEAD_TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0,
    localparam int DEPTH_1 = HEAD_TENSOR_SIZE_DIM_1 / PARALLELISM_DIM_1,
    localparam int BLOCK   = PARALLELISM_DIM_0 * PARALLELISM_DIM_1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data [NUM_HEADS*BLOCK],
    input  logic [NUM_HEADS-1:0]  in_valid,
    output logic [NUM_HEADS-1:0]  in_ready,
    output logic [DATA_WIDTH-1:0] out_data [BLOCK],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_row_last,
    output logic                  out_last
`ifdef ATTENTION_HEAD_CONCAT_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           starve_cnt
`endif
);

    localparam int CW = (DEPTH_0 > 1) ? $clog2(DEPTH_0) : 1;
    localparam int HW = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1;
    localparam int RW = (DEPTH_1 > 1) ? $clog2(DEPTH_1) : 1;

    generate
        if (NUM_HEADS < 1) begin : g_bad_heads
            $fatal(1, "NUM_HEADS must be at least 1");
        end
        if ((HEAD_TENSOR_SIZE_DIM_0 % PARALLELISM_DIM_0) != 0) begin : g_bad_dim0
            $fatal(1, "HEAD_TENSOR_SIZE_DIM_0 not divisible by PARALLELISM_DIM_0");
        end
        if ((HEAD_TENSOR_SIZE_DIM_1 % PARALLELISM_DIM_1) != 0) begin : g_bad_dim1
            $fatal(1, "HEAD_TENSOR_SIZE_DIM_1 not divisible by PARALLELISM_DIM_1");
        end
    endgenerate

    logic [CW-1:0]         col_cnt_r;
    logic [HW-1:0]         head_idx_r;
    logic [RW-1:0]         row_cnt_r;
    logic                  load_en_s;
    logic                  cur_valid_s;
    logic                  accept_s;
    logic                  col_last_s;
    logic                  head_last_s;
    logic                  row_wrap_s;
    logic                  row_last_s;
    logic [DATA_WIDTH-1:0] sel_data_s [BLOCK];

    assign load_en_s   = !out_valid || out_ready;
    assign accept_s    = cur_valid_s && load_en_s;
    assign col_last_s  = (col_cnt_r == CW'(DEPTH_0 - 1));
    assign head_last_s = (head_idx_r == HW'(NUM_HEADS - 1));
    assign row_wrap_s  = (row_cnt_r == RW'(DEPTH_1 - 1));
    assign row_last_s  = col_last_s && head_last_s;

    // AND-OR mux of the selected head's valid and block; selection never looks at in_valid.
    always_comb begin
        sel_data_s  = '{default: '0};
        cur_valid_s = 1'b0;
        for (int h = 0; h < NUM_HEADS; h++) begin
            cur_valid_s = cur_valid_s | (in_valid[h] & (head_idx_r == HW'(h)));
            for (int i = 0; i < BLOCK; i++) begin
                sel_data_s[i] = sel_data_s[i]
                              | (in_data[h*BLOCK+i] & {DATA_WIDTH{head_idx_r == HW'(h)}});
            end
        end
    end

    // One-hot ready towards the head currently owed a block; held low during reset.
    always_comb begin
        in_ready = '0;
        for (int h = 0; h < NUM_HEADS; h++) begin
            in_ready[h] = !rst && load_en_s && (head_idx_r == HW'(h));
        end
    end

    // Output register: loads on accept, drains on downstream handshake, holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_row_last <= 1'b0;
            out_last     <= 1'b0;
            out_data     <= '{default: '0};
        end else if (accept_s) begin
            out_valid    <= 1'b1;
            out_data     <= sel_data_s;
            out_row_last <= row_last_s;
            out_last     <= row_last_s && row_wrap_s;
        end else if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
        end else begin
            out_valid    <= out_valid;
        end
    end

    // Position counters: column fastest, then head, then block-row; wrap seamlessly into the next tensor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt_r  <= '0;
            head_idx_r <= '0;
            row_cnt_r  <= '0;
        end else if (accept_s) begin
            if (col_last_s) begin
                col_cnt_r <= '0;
                if (head_last_s) begin
                    head_idx_r <= '0;
                    row_cnt_r  <= row_wrap_s ? '0 : row_cnt_r + RW'(1);
                end else begin
                    head_idx_r <= head_idx_r + HW'(1);
                end
            end else begin
                col_cnt_r <= col_cnt_r + CW'(1);
            end
        end else begin
            col_cnt_r <= col_cnt_r;
        end
    end

`ifdef ATTENTION_HEAD_CONCAT_STALL_CNT_EN
    // Saturating counters of downstream stalls and upstream starvation for the selected head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= 32'd0;
            starve_cnt <= 32'd0;
        end else begin
            if (cur_valid_s && !load_en_s && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (load_en_s && !cur_valid_s && (starve_cnt != 32'hFFFF_FFFF)) begin
                starve_cnt <= starve_cnt + 32'd1;
            end else begin
                starve_cnt <= starve_cnt;
            end
        end
    end
`endif

endmodule
